// File: rtl/fp_add_pkg.sv
// Shared definitions for the FP adder pipeline: exponent bias helpers, aligned
// word width and the alignment-stage state encoding.
package fp_add_pkg;

  function automatic int bias(input int e_width);
    return (1 << (e_width - 1)) - 1;
  endfunction

  // Unbiased code that a biased exponent of zero (denormal/zero) maps to.
  function automatic int denorm_exp(input int e_width);
    return (1 << e_width) - bias(e_width);
  endfunction

  // {hidden, fraction, guard, round, sticky}
  function automatic int aligned_width(input int m_width);
    return m_width + 4;
  endfunction

  localparam int AW = aligned_width(23);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } align_state_t;

endpackage

// File: rtl/sticky_rshift.sv
// Combinational right shift by a small amount; every bit shifted out is
// OR-ed into the LSB of the result so no nonzero information is lost.
module sticky_rshift #(
  parameter int W     = 27,
  parameter int AMT_W = 3
) (
  input  logic [W-1:0]     word,
  input  logic [AMT_W-1:0] amt,
  output logic [W-1:0]     result
);

  logic lost;

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    lost = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i < int'(amt)) lost = lost | word[i];
    end
    result    = word >> amt;
    result[0] = result[0] | lost;
  end

endmodule

// File: rtl/align_shift.sv
// FP adder alignment stage: restores hidden bits, orders the operands by
// exponent and shifts the smaller one right, STEP bits per cycle, with sticky.
module align_shift
  import fp_add_pkg::*;
#(
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 23,
  parameter int STEP    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sign_A,
  input  logic                 sign_B,
  input  logic [E_WIDTH-1:0]   exp_A,
  input  logic [E_WIDTH-1:0]   exp_B,
  input  logic [M_WIDTH-1:0]   mnt_A,
  input  logic [M_WIDTH-1:0]   mnt_B,
  input  logic [E_WIDTH-1:0]   exp_diff,
  input  logic                 gt_lt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sign_big,
  output logic                 sign_small,
  output logic [E_WIDTH-1:0]   exp_big,
  output logic [M_WIDTH+3:0]   mnt_big,
  output logic [M_WIDTH+3:0]   mnt_small,
  output logic                 eff_sub
);

  localparam int ALN_W = aligned_width(M_WIDTH);
  localparam int REM_W = $clog2(ALN_W);
  localparam int AMT_W = $clog2(STEP + 1);
  localparam logic [E_WIDTH-1:0] DENORM = E_WIDTH'(denorm_exp(E_WIDTH));

  align_state_t     state, state_d;
  logic             valid_d;
  logic [REM_W-1:0] rem_q, rem_init;
  logic [AMT_W-1:0] shamt;
  logic [ALN_W-1:0] aligned_a, aligned_b, shifted;

  assign aligned_a = {exp_A != DENORM, mnt_A, 3'b000};
  assign aligned_b = {exp_B != DENORM, mnt_B, 3'b000};
  assign in_ready  = (state == IDLE);

  // Shifting by ALN_W-1 already leaves only the sticky bit, so larger distances are capped.
  always_comb begin
    if (int'(exp_diff) >= ALN_W - 1) rem_init = REM_W'(ALN_W - 1);
    else                             rem_init = REM_W'(exp_diff);
  end

  always_comb begin
    if (int'(rem_q) > STEP) shamt = AMT_W'(STEP);
    else                    shamt = AMT_W'(rem_q);
  end

  sticky_rshift #(
    .W     (ALN_W),
    .AMT_W (AMT_W)
  ) u_sticky_rshift (
    .word   (mnt_small),
    .amt    (shamt),
    .result (shifted)
  );

  // out_valid rises one cycle after DONE is entered and drops on the handshake.
  always_comb begin
    state_d = state;
    valid_d = out_valid;
    unique case (state)
      IDLE: begin
        if (in_valid) state_d = (rem_init == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (rem_q == REM_W'(shamt)) state_d = DONE;
      end
      DONE: begin
        if (!out_valid) begin
          valid_d = 1'b1;
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      out_valid <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_big   <= 1'b0;
      sign_small <= 1'b0;
      exp_big    <= '0;
      mnt_big    <= '0;
      mnt_small  <= '0;
      eff_sub    <= 1'b0;
      rem_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign_big   <= gt_lt ? sign_A : sign_B;
            sign_small <= gt_lt ? sign_B : sign_A;
            exp_big    <= gt_lt ? exp_A : exp_B;
            mnt_big    <= gt_lt ? aligned_a : aligned_b;
            mnt_small  <= gt_lt ? aligned_b : aligned_a;
            eff_sub    <= sign_A ^ sign_B;
            rem_q      <= rem_init;
          end
        end
        SHIFT: begin
          mnt_small <= shifted;
          rem_q     <= rem_q - REM_W'(shamt);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_align_shift.sv
// Scoreboard bench for align_shift: directed operand pairs push hand-computed
// results; a monitor pops and compares on every output handshake.
module tb_align_shift;

  typedef struct {
    string       name;
    logic        sign_big;
    logic        sign_small;
    logic [7:0]  exp_big;
    logic [26:0] mnt_big;
    logic [26:0] mnt_small;
    logic        eff_sub;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_A = 1'b0, sign_B = 1'b0;
  logic [7:0]  exp_A = '0, exp_B = '0, exp_diff = '0;
  logic [22:0] mnt_A = '0, mnt_B = '0;
  logic        gt_lt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        sign_big, sign_small, eff_sub;
  logic [7:0]  exp_big;
  logic [26:0] mnt_big, mnt_small;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t sb[$];

  align_shift #(.E_WIDTH(8), .M_WIDTH(23), .STEP(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign_A     (sign_A),
    .sign_B     (sign_B),
    .exp_A      (exp_A),
    .exp_B      (exp_B),
    .mnt_A      (mnt_A),
    .mnt_B      (mnt_B),
    .exp_diff   (exp_diff),
    .gt_lt      (gt_lt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sign_big   (sign_big),
    .sign_small (sign_small),
    .exp_big    (exp_big),
    .mnt_big    (mnt_big),
    .mnt_small  (mnt_small),
    .eff_sub    (eff_sub)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string what, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", what, act, req);
    end
  endtask

  // Presents one operand pair and pushes its expected result once accepted.
  task automatic send(input logic sa, input logic sbit, input logic [7:0] ea, input logic [7:0] eb,
                      input logic [22:0] ma, input logic [22:0] mb, input logic [7:0] diff,
                      input logic gl, input exp_t e);
    int n;
    @(negedge clk);
    sign_A = sa; sign_B = sbit; exp_A = ea; exp_B = eb;
    mnt_A = ma; mnt_B = mb; exp_diff = diff; gt_lt = gl;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({e.name, " accept timeout"}, 64'(in_ready), 64'(1));
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      e.acc = cyc;
      sb.push_back(e);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string what);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({what, " drained"}, 64'(sb.size()), 64'(0));
  endtask

  // Monitor: latency is measured from the accept edge to the first out_valid.
  initial begin
    exp_t e;
    bit   seen = 1'b0;
    int   first = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          seen  = 1'b1;
          first = cyc;
        end
        if (out_ready) begin
          seen = 1'b0;
          if (sb.size() == 0) begin
            check("unexpected output", 64'(1), 64'(0));
          end else begin
            e = sb.pop_front();
            check({e.name, " latency"},    64'(first - e.acc), 64'(e.lat));
            check({e.name, " mnt_big"},    64'(mnt_big),       64'(e.mnt_big));
            check({e.name, " mnt_small"},  64'(mnt_small),     64'(e.mnt_small));
            check({e.name, " exp_big"},    64'(exp_big),       64'(e.exp_big));
            check({e.name, " sign_big"},   64'(sign_big),      64'(e.sign_big));
            check({e.name, " sign_small"}, 64'(sign_small),    64'(e.sign_small));
            check({e.name, " eff_sub"},    64'(eff_sub),       64'(e.eff_sub));
            check({e.name, " in_ready"},   64'(in_ready),      64'(0));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_idle_zero(input string what);
    check({what, " out_valid"},  64'(out_valid),  64'(0));
    check({what, " in_ready"},   64'(in_ready),   64'(1));
    check({what, " mnt_big"},    64'(mnt_big),    64'(0));
    check({what, " mnt_small"},  64'(mnt_small),  64'(0));
    check({what, " exp_big"},    64'(exp_big),    64'(0));
    check({what, " signs"},      64'({sign_big, sign_small}), 64'(0));
    check({what, " eff_sub"},    64'(eff_sub),    64'(0));
  endtask

  initial begin
    exp_t e_one   = '{"one_half",   0, 0, 8'h00, 27'h4000000, 27'h2000000, 0, 2, 0};
    exp_t e_equal = '{"equal_exp",  0, 0, 8'h00, 27'h4000008, 27'h4000018, 0, 1, 0};
    exp_t e_cap   = '{"cap30",      0, 0, 8'h10, 27'h6000000, 27'h0000001, 0, 8, 0};
    exp_t e_den   = '{"denorm",     1, 0, 8'h82, 27'h4000000, 27'h0000080, 1, 1, 0};
    exp_t e_st5   = '{"sticky5",    1, 0, 8'h05, 27'h4000000, 27'h0200001, 1, 3, 0};
    exp_t e_st4   = '{"step4",      0, 0, 8'h04, 27'h4000000, 27'h0400001, 0, 2, 0};
    exp_t e_rst   = '{"killed",     0, 0, 8'h14, 27'h4000000, 27'h0000000, 0, 6, 0};
    logic [26:0] snap_small, snap_big;
    int n;

    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;

    send(0, 0, 8'h00, 8'hFF, 23'h0, 23'h0, 8'd1, 1, e_one);
    send(0, 0, 8'h00, 8'h00, 23'h3, 23'h1, 8'd0, 0, e_equal);
    send(0, 0, 8'h10, 8'hF2, 23'h400000, 23'h1, 8'd30, 1, e_cap);
    send(1, 0, 8'h82, 8'h81, 23'h0, 23'h10, 8'd0, 1, e_den);
    send(0, 1, 8'h00, 8'h05, 23'h3, 23'h0, 8'd5, 0, e_st5);
    send(0, 0, 8'h04, 8'h00, 23'h0, 23'h3, 8'd4, 1, e_st4);
    drain("directed");

    // Backpressure: hold out_ready low in DONE while a new operand waits.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(0, 0, 8'h00, 8'hFF, 23'h0, 23'h0, 8'd1, 1, e_one);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp out_valid rises", 64'(out_valid), 64'(1));
    snap_small = mnt_small;
    snap_big   = mnt_big;
    fork
      send(0, 0, 8'h00, 8'h00, 23'h3, 23'h1, 8'd0, 0, e_equal);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp out_valid held", 64'(out_valid), 64'(1));
          check("bp in_ready low",   64'(in_ready),  64'(0));
          check("bp mnt_small held", 64'(mnt_small), 64'(snap_small));
          check("bp mnt_big held",   64'(mnt_big),   64'(snap_big));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("backpressure");

    // Reset in the middle of a 20-bit shift discards the operand.
    send(0, 0, 8'h14, 8'h00, 23'h0, 23'h0, 8'd20, 1, e_rst);
    repeat (2) @(negedge clk);
    check("pre-reset in_ready", 64'(in_ready), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    check_idle_zero("mid-shift reset");
    @(negedge clk);
    rst = 1'b0;
    send(0, 0, 8'h04, 8'h00, 23'h0, 23'h3, 8'd4, 1, e_st4);
    drain("after reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
